fetch_unit: RTL and testbench

Instruction-fetch stage directly upstream of the decode stage. It owns the program counter, drives a 1-cycle-latency block-RAM instruction memory and presents `pc_out`/`command`/`valid` to decode, which latches them when its enable is high. It waits for the program loader before fetching, holds its state while decode stalls, and redirects on taken branches from execute. It also stops fetching permanently on a halt request.

---
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_unit.sv | 105 ++++++++++
 tb/tb_fetch_unit.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-to-environment bundle: loader/decode/execute controls, instruction BRAM port and decode-facing outputs.
interface fetch_unit_if #(
  parameter int IMEM_AW = 15
);
  logic               load_done;
  logic               stall;
  logic               branch_taken;
  logic [31:0]        branch_target;
  logic               halt;
  logic               imem_en;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata;
  logic [31:0]        pc_out;
  logic [31:0]        command;
  logic               valid;
  logic               halted;

  modport master (
    input  load_done, stall, branch_taken, branch_target, halt, imem_rdata,
    output imem_en, imem_addr, pc_out, command, valid, halted
  );

  modport slave (
    output load_done, stall, branch_taken, branch_target, halt, imem_rdata,
    input  imem_en, imem_addr, pc_out, command, valid, halted
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage feeding a 1-cycle-latency BRAM to decode; waits for load, stalls, redirects, halts.
// Optional FETCH_PERF_CNT_EN adds fetch_cnt / bubble_cnt performance counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          IMEM_AW  = 15
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]  fetch_cnt,
  output logic [31:0]  bubble_cnt
`endif
);

  typedef enum logic [1:0] {S_WAIT, S_RUN, S_HALT} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_next_pc, w_next_pc_nxt;
  logic [31:0] r_cur_pc, w_cur_pc_nxt;
  logic        r_cur_valid, w_cur_valid_nxt;
  logic        w_imem_en;
  logic [31:0] w_fetch_addr;
  logic [31:0] w_target;
  logic        w_valid;
  logic        w_unused_addr_bits;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_WAIT;
      r_next_pc   <= RESET_PC;
      r_cur_pc    <= 32'h0;
      r_cur_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_next_pc   <= w_next_pc_nxt;
      r_cur_pc    <= w_cur_pc_nxt;
      r_cur_valid <= w_cur_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_next_pc_nxt   = r_next_pc;
    w_cur_pc_nxt    = r_cur_pc;
    w_cur_valid_nxt = r_cur_valid;
    w_imem_en       = 1'b0;
    w_fetch_addr    = 32'h0;
    w_target        = bus.branch_target & ~32'd3;
    case (r_state)
      S_WAIT: begin
        if (bus.load_done) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (bus.halt) begin
          w_state_nxt     = S_HALT;
          w_cur_valid_nxt = 1'b0;
        end else if (bus.branch_taken) begin
          w_imem_en       = 1'b1;
          w_fetch_addr    = w_target;
          w_cur_pc_nxt    = w_target;
          w_next_pc_nxt   = w_target + 32'd4;
          w_cur_valid_nxt = 1'b1;
        end else if (!bus.stall) begin
          w_imem_en       = 1'b1;
          w_fetch_addr    = r_next_pc;
          w_cur_pc_nxt    = r_next_pc;
          w_next_pc_nxt   = r_next_pc + 32'd4;
          w_cur_valid_nxt = 1'b1;
        end
        // Stall: BRAM enable stays low so its output register keeps the current word.
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: w_state_nxt = S_WAIT;
    endcase
  end

  // The wrong-path word sitting on the BRAM output during a redirect is squashed here.
  assign w_valid = r_cur_valid & (r_state == S_RUN) & ~bus.branch_taken;

  assign bus.imem_en   = w_imem_en;
  assign bus.imem_addr = w_fetch_addr[IMEM_AW+1:2];
  assign bus.pc_out    = r_cur_pc;
  assign bus.command   = bus.imem_rdata;
  assign bus.valid     = w_valid;
  assign bus.halted    = (r_state == S_HALT);

  assign w_unused_addr_bits = ^{w_fetch_addr[31:IMEM_AW+2], w_fetch_addr[1:0]};

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt  <= 32'h0;
      bubble_cnt <= 32'h0;
    end else begin
      if (w_valid && !bus.stall) fetch_cnt <= fetch_cnt + 32'd1;
      if ((r_state == S_RUN) && !w_valid) bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed boot/stall/branch/wrap/halt/reset scenarios plus randomized run.
module tb_fetch_unit;
  localparam int AW = 15;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] mem [0:(1<<AW)-1];

  always #5 clk = ~clk;

  fetch_unit_if #(.IMEM_AW(AW)) bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, bubble_cnt;
`endif

  fetch_unit #(.RESET_PC(32'h0), .IMEM_AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt  (fetch_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  // Block RAM with one cycle of read latency and an enabled output register.
  always @(posedge clk) if (bus.imem_en) bus.imem_rdata <= mem[bus.imem_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit ld, input bit st, input bit br, input logic [31:0] tgt, input bit hl);
    bus.load_done = ld; bus.stall = st; bus.branch_taken = br; bus.branch_target = tgt; bus.halt = hl;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 0, 32'h0, 0);
    tick(); tick();
    #1;
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.valid); end
    checks++; if (bus.imem_en !== 1'b0) begin errors++; $display("FAIL reset_en got %b want 0", bus.imem_en); end
    checks++; if (bus.imem_addr !== '0) begin errors++; $display("FAIL reset_addr got %h want 0", bus.imem_addr); end
    checks++; if (bus.pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", bus.pc_out); end
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", bus.halted); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_boot();
    for (int c = 0; c <= 10; c++) begin
      drive(c >= 5, 0, 0, 32'h0, 0);
      #1;
      checks++;
      if (bus.valid !== (c >= 7)) begin errors++; $display("FAIL boot_valid c=%0d got %b want %b", c, bus.valid, c >= 7); end
      if (c == 6) begin
        checks++;
        if (bus.imem_en !== 1'b1 || bus.imem_addr !== '0) begin
          errors++; $display("FAIL boot_first_read en=%b addr=%h want en=1 addr=0", bus.imem_en, bus.imem_addr);
        end
      end
      if (c >= 7) begin
        checks++;
        if (bus.pc_out !== 32'((c - 7) * 4) || bus.command !== mem[c - 7]) begin
          errors++; $display("FAIL boot_word c=%0d pc=%h cmd=%h want pc=%h cmd=%h", c, bus.pc_out, bus.command, (c - 7) * 4, mem[c - 7]);
        end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 32'h0, 0);
      #1;
      checks++;
      if (bus.valid !== 1'b1 || bus.pc_out !== 32'h10 || bus.command !== mem[4] || bus.imem_en !== 1'b0) begin
        errors++; $display("FAIL stall_hold i=%0d v=%b pc=%h cmd=%h en=%b want v=1 pc=10 cmd=%h en=0", i, bus.valid, bus.pc_out, bus.command, bus.imem_en, mem[4]);
      end
      tick();
    end
    drive(1, 0, 0, 32'h0, 0);
    #1;
    checks++; if (bus.pc_out !== 32'h10) begin errors++; $display("FAIL stall_release pc=%h want 10", bus.pc_out); end
    tick();
    checks++;
    if (bus.pc_out !== 32'h14 || bus.command !== mem[5] || bus.valid !== 1'b1) begin
      errors++; $display("FAIL stall_next pc=%h cmd=%h v=%b want pc=14 cmd=%h v=1", bus.pc_out, bus.command, bus.valid, mem[5]);
    end
    tick();
  endtask

  task automatic test_branch();
    tick(); tick();
    drive(1, 0, 1, 32'h100, 0);
    #1;
    checks++;
    if (bus.pc_out !== 32'h20 || bus.valid !== 1'b0 || bus.imem_en !== 1'b1 || bus.imem_addr !== 15'h40) begin
      errors++; $display("FAIL branch_cycle pc=%h v=%b en=%b addr=%h want pc=20 v=0 en=1 addr=40", bus.pc_out, bus.valid, bus.imem_en, bus.imem_addr);
    end
    tick();
    drive(1, 0, 0, 32'h0, 0);
    #1;
    checks++;
    if (bus.pc_out !== 32'h100 || bus.command !== mem[64] || bus.valid !== 1'b1) begin
      errors++; $display("FAIL branch_target pc=%h cmd=%h v=%b want pc=100 cmd=%h v=1", bus.pc_out, bus.command, bus.valid, mem[64]);
    end
    tick();
    checks++;
    if (bus.pc_out !== 32'h104 || bus.command !== mem[65]) begin
      errors++; $display("FAIL branch_follow pc=%h cmd=%h want pc=104 cmd=%h", bus.pc_out, bus.command, mem[65]);
    end
  endtask

  task automatic test_branch_stall();
    drive(1, 1, 1, 32'h203, 0);
    #1;
    checks++;
    if (bus.valid !== 1'b0 || bus.imem_en !== 1'b1 || bus.imem_addr !== 15'h80) begin
      errors++; $display("FAIL brstall_cycle v=%b en=%b addr=%h want v=0 en=1 addr=80", bus.valid, bus.imem_en, bus.imem_addr);
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 0, 32'h0, 0);
      #1;
      checks++;
      if (bus.pc_out !== 32'h200 || bus.command !== mem[128] || bus.valid !== 1'b1 || bus.imem_en !== 1'b0) begin
        errors++; $display("FAIL brstall_hold i=%0d pc=%h cmd=%h v=%b en=%b want pc=200 cmd=%h v=1 en=0", i, bus.pc_out, bus.command, bus.valid, bus.imem_en, mem[128]);
      end
      tick();
    end
    drive(1, 0, 0, 32'h0, 0);
    tick();
    checks++;
    if (bus.pc_out !== 32'h204 || bus.command !== mem[129]) begin
      errors++; $display("FAIL brstall_follow pc=%h cmd=%h want pc=204 cmd=%h", bus.pc_out, bus.command, mem[129]);
    end
  endtask

  task automatic test_wrap();
    drive(1, 0, 1, 32'hFFFF_FFFC, 0);
    #1;
    checks++; if (bus.imem_addr !== 15'h7FFF) begin errors++; $display("FAIL wrap_addr got %h want 7fff", bus.imem_addr); end
    tick();
    drive(1, 0, 0, 32'h0, 0);
    #1;
    checks++;
    if (bus.pc_out !== 32'hFFFF_FFFC || bus.command !== mem[(1<<AW)-1] || bus.imem_addr !== '0) begin
      errors++; $display("FAIL wrap_top pc=%h cmd=%h addr=%h want pc=fffffffc cmd=%h addr=0", bus.pc_out, bus.command, bus.imem_addr, mem[(1<<AW)-1]);
    end
    tick();
    checks++;
    if (bus.pc_out !== 32'h0 || bus.command !== mem[0] || bus.valid !== 1'b1) begin
      errors++; $display("FAIL wrap_zero pc=%h cmd=%h v=%b want pc=0 cmd=%h v=1", bus.pc_out, bus.command, bus.valid, mem[0]);
    end
    tick();
  endtask

  task automatic test_halt();
    drive(1, 0, 1, 32'h300, 1);
    #1;
    checks++; if (bus.imem_en !== 1'b0) begin errors++; $display("FAIL halt_en got %b want 0", bus.imem_en); end
    tick();
    for (int i = 0; i < 6; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom, 0);
      #1;
      checks++;
      if (bus.halted !== 1'b1 || bus.valid !== 1'b0 || bus.imem_en !== 1'b0 || bus.pc_out !== 32'h4) begin
        errors++; $display("FAIL halt_hold i=%0d h=%b v=%b en=%b pc=%h want h=1 v=0 en=0 pc=4", i, bus.halted, bus.valid, bus.imem_en, bus.pc_out);
      end
      tick();
    end
    rst = 1'b1;
    #1;
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL halt_reset got %b want 0", bus.halted); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_async_reset();
    drive(1, 0, 0, 32'h0, 0);
    tick(); tick(); tick();
    checks++;
    if (bus.valid !== 1'b1 || bus.pc_out !== 32'h4) begin
      errors++; $display("FAIL areset_pre v=%b pc=%h want v=1 pc=4", bus.valid, bus.pc_out);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.valid !== 1'b0 || bus.pc_out !== 32'h0 || bus.imem_en !== 1'b0) begin
      errors++; $display("FAIL areset_now v=%b pc=%h en=%b want v=0 pc=0 en=0", bus.valid, bus.pc_out, bus.imem_en);
    end
    tick();
    rst = 1'b0;
    drive(0, 0, 1, 32'h40, 0);
    tick();
    checks++;
    if (bus.valid !== 1'b0 || bus.imem_en !== 1'b0) begin
      errors++; $display("FAIL areset_wait v=%b en=%b want v=0 en=0", bus.valid, bus.imem_en);
    end
  endtask

  // Reference: after loading, each delivered word is the previous PC + 4, or the aligned
  // branch target when a redirect is accepted; a stall repeats the word already shown.
  task automatic test_random();
    bit          running, have_word, ld, st, br, exp_v, exp_en;
    logic [31:0] shown_pc, upcoming_pc, tgt, fa;
    rst = 1'b1;
    drive(0, 0, 0, 32'h0, 0);
    tick();
    rst = 1'b0;
    running = 0; have_word = 0; shown_pc = 0; upcoming_pc = 0;
    for (int c = 0; c < 400; c++) begin
      ld  = ($urandom_range(0, 3) == 0);
      st  = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 6) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31))) : $urandom;
      drive(ld, st, br, tgt, 0);
      #1;
      exp_v  = running && have_word && !br;
      exp_en = running && (br || !st);
      fa     = br ? {tgt[31:2], 2'b00} : upcoming_pc;
      checks++;
      if (bus.valid !== exp_v || bus.imem_en !== exp_en || bus.halted !== 1'b0) begin
        errors++; $display("FAIL rand_ctl c=%0d v=%b en=%b h=%b want v=%b en=%b h=0", c, bus.valid, bus.imem_en, bus.halted, exp_v, exp_en);
      end
      if (exp_v) begin
        checks++;
        if (bus.pc_out !== shown_pc || bus.command !== mem[shown_pc[AW+1:2]]) begin
          errors++; $display("FAIL rand_word c=%0d pc=%h cmd=%h want pc=%h cmd=%h", c, bus.pc_out, bus.command, shown_pc, mem[shown_pc[AW+1:2]]);
        end
      end
      if (exp_en) begin
        checks++;
        if (bus.imem_addr !== fa[AW+1:2]) begin
          errors++; $display("FAIL rand_addr c=%0d got %h want %h", c, bus.imem_addr, fa[AW+1:2]);
        end
      end
      if (!running) running = ld;
      else if (exp_en) begin
        shown_pc    = fa;
        upcoming_pc = fa + 32'd4;
        have_word   = 1;
      end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
    bus.imem_rdata = 32'h0;
    test_reset();
    test_boot();
    test_stall();
    test_branch();
    tick();
    test_branch_stall();
    tick();
    test_wrap();
    test_halt();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout reached without completion");
    $fatal(1, "timeout");
  end
endmodule
